if_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC. Issues word fetches to instruction memory through a req/ready plus valid handshake.
- Buffers up to two returned instructions and presents inst/pc pairs to IF/ID.
- Handles branch/jump redirects from EX by flushing local state and raising the IF/ID flush.

---
 rtl/pipeline_pkg.sv | 12 +
 rtl/fetch_queue.sv | 42 ++++
 rtl/if_fetch_unit.sv | 69 ++++++
 tb/tb_if_fetch_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared constants and the fetch-queue entry type for the front end.
package pipeline_pkg;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] BUBBLE_INST = 32'h0;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0] pc;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: two-entry {inst, pc} FIFO with sync clear; head reads as a bubble when empty.
module fetch_queue
  import pipeline_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clr_i,
  input  logic      push_i,
  input  fq_entry_t push_data_i,
  input  logic      pop_i,
  output logic [1:0] occ_o,
  output fq_entry_t head_o
);
  fq_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0] occ_q, occ_d, keep;
  assign keep = occ_q - {1'b0, pop_i};
  always_comb begin
    e0_d  = pop_i ? e1_q : e0_q;
    e1_d  = pop_i ? '0 : e1_q;
    occ_d = occ_q + {1'b0, push_i} - {1'b0, pop_i};
    if (push_i && keep == 2'd0) e0_d = push_data_i;
    if (push_i && keep != 2'd0) e1_d = push_data_i;
    if (clr_i) begin
      e0_d  = '0;
      e1_d  = '0;
      occ_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end
  assign occ_o  = occ_q;
  assign head_o = (occ_q == 2'd0) ? '{inst: BUBBLE_INST, pc: 32'h0} : e0_q;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the PC, issues word fetches, buffers two responses and feeds IF/ID.
module if_fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        flush_o
);
  localparam logic [2:0] QD = 3'(QDEPTH);
  logic [31:0] pc_q, pc_d, ppc_q, ppc_d;
  logic out_q, out_d, kill_q, kill_d;
  logic [1:0] occ;
  logic [2:0] cnt;
  logic deq, resp, accept, push;
  fq_entry_t head;
  assign deq    = ~stall_i & ~redirect_i & (occ != 2'd0);
  assign resp   = imem_valid_i & out_q;
  assign cnt    = {1'b0, occ} + {2'b0, out_q} - {2'b0, deq};
  // Counting the outstanding request as occupied guarantees its response a slot.
  assign imem_req_o = rst_n & ~redirect_i & ~kill_q & (~out_q | imem_valid_i) & (cnt < QD);
  assign accept = imem_req_o & imem_ready_i;
  assign push   = resp & ~kill_q & ~redirect_i;
  always_comb begin
    pc_d   = redirect_i ? (redirect_pc_i & PC_ALIGN_MASK) : accept ? pc_q + PC_STEP : pc_q;
    ppc_d  = accept ? pc_q : ppc_q;
    out_d  = accept | (out_q & ~resp);
    kill_d = redirect_i ? (out_q & ~imem_valid_i) : (kill_q & ~resp);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      ppc_q  <= '0;
      out_q  <= 1'b0;
      kill_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ppc_q  <= ppc_d;
      out_q  <= out_d;
      kill_q <= kill_d;
    end
  end
  fetch_queue u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (redirect_i),
    .push_i      (push),
    .push_data_i ('{inst: imem_rdata_i, pc: ppc_q}),
    .pop_i       (deq),
    .occ_o       (occ),
    .head_o      (head)
  );
  assign imem_addr_o = pc_q;
  assign inst_o      = head.inst;
  assign pc_o        = head.pc;
  assign flush_o     = redirect_i;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed cycle table, random scoreboard run, wrap and mid-flight reset checks.
module tb_if_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall_i = 1'b0, redirect_i = 1'b0, imem_ready_i = 1'b0, imem_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0, imem_rdata_i = '0;
  logic imem_req_o, flush_o;
  logic [31:0] imem_addr_o, inst_o, pc_o;
  logic req2, flush2;
  logic [31:0] addr2, inst2, pc2;
  int checks = 0, failures = 0;
  logic pend = 1'b0, mv = 1'b1;
  logic [31:0] pend_addr = '0, xm = '0;
  typedef struct packed {logic [31:0] inst; logic [31:0] pc;} exp_t;
  exp_t sb[$];
  typedef struct {
    logic st, rd; logic [31:0] rpc; logic rdy, mv, req;
    logic [31:0] addr, inst; logic fl;
  } vec_t;
  vec_t tbl[22];

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_valid_i(imem_valid_i), .imem_rdata_i(imem_rdata_i),
    .inst_o(inst_o), .pc_o(pc_o), .flush_o(flush_o)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall_i(1'b0), .redirect_i(1'b0),
    .redirect_pc_i(32'h0), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_ready_i(1'b1), .imem_valid_i(1'b0), .imem_rdata_i(32'h0),
    .inst_o(inst2), .pc_o(pc2), .flush_o(flush2)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask

  task automatic mem_out();
    imem_valid_i = pend & mv;
    imem_rdata_i = pend ? (pend_addr ^ xm) : 32'h0;
  endtask

  task automatic edge_step();
    logic acc, rsp;
    logic [31:0] a;
    acc = imem_req_o & imem_ready_i;
    rsp = imem_valid_i;
    a   = imem_addr_o;
    @(posedge clk);
    #1;
    if (acc) begin
      pend = 1'b1;
      pend_addr = a;
    end else if (rsp) pend = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic stale, rsp;
    int consumed;
    tbl = '{
      '{0,0,32'h0,  1,1, 1,32'h000,32'h000,0},
      '{0,0,32'h0,  1,1, 1,32'h004,32'h000,0},
      '{0,0,32'h0,  1,1, 1,32'h008,32'h000,0},
      '{0,0,32'h0,  1,1, 1,32'h00C,32'h004,0},
      '{0,0,32'h0,  1,1, 1,32'h010,32'h008,0},
      '{1,0,32'h0,  1,1, 0,32'h014,32'h00C,0},
      '{1,0,32'h0,  1,1, 0,32'h014,32'h00C,0},
      '{1,0,32'h0,  1,1, 0,32'h014,32'h00C,0},
      '{0,0,32'h0,  1,1, 1,32'h014,32'h00C,0},
      '{0,0,32'h0,  1,1, 1,32'h018,32'h010,0},
      '{0,0,32'h0,  1,1, 1,32'h01C,32'h014,0},
      '{0,0,32'h0,  1,1, 1,32'h020,32'h018,0},
      '{0,1,32'h103,1,0, 0,32'h024,32'h01C,1},
      '{0,0,32'h0,  1,1, 0,32'h100,32'h000,0},
      '{0,0,32'h0,  1,1, 1,32'h100,32'h000,0},
      '{0,0,32'h0,  1,1, 1,32'h104,32'h000,0},
      '{0,0,32'h0,  1,1, 1,32'h108,32'h100,0},
      '{0,0,32'h0,  0,1, 1,32'h10C,32'h104,0},
      '{0,0,32'h0,  0,1, 1,32'h10C,32'h108,0},
      '{0,0,32'h0,  1,1, 1,32'h10C,32'h000,0},
      '{0,0,32'h0,  1,1, 1,32'h110,32'h000,0},
      '{0,0,32'h0,  1,1, 1,32'h114,32'h10C,0}
    };
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req_o), 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_addr_wrap", addr2, 32'hFFFF_FFFC);
    rst_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      stall_i = tbl[i].st;
      redirect_i = tbl[i].rd;
      redirect_pc_i = tbl[i].rpc;
      imem_ready_i = tbl[i].rdy;
      mv = tbl[i].mv;
      mem_out();
      #1;
      chk($sformatf("r%0d_req", i), 32'(imem_req_o), 32'(tbl[i].req));
      chk($sformatf("r%0d_addr", i), imem_addr_o, tbl[i].addr);
      chk($sformatf("r%0d_inst", i), inst_o, tbl[i].inst);
      chk($sformatf("r%0d_pc", i), pc_o, tbl[i].inst);
      chk($sformatf("r%0d_flush", i), 32'(flush_o), 32'(tbl[i].fl));
      if (i == 0) chk("wrap_first", addr2, 32'hFFFF_FFFC);
      if (i == 1) chk("wrap_second", addr2, 32'h0);
      edge_step();
    end
    xm = 32'hDEAD_0000;
    exp_pc = '0;
    stale = 1'b0;
    consumed = 0;
    for (int n = 0; n < 400; n++) begin
      stall_i = ($urandom_range(0, 3) == 0);
      redirect_i = (n == 0) || ($urandom_range(0, 15) == 0);
      redirect_pc_i = $urandom;
      imem_ready_i = ($urandom_range(0, 3) != 0);
      mv = ($urandom_range(0, 2) != 0);
      mem_out();
      #1;
      chk("sb_flush", 32'(flush_o), 32'(redirect_i));
      if (redirect_i) chk("sb_noreq", 32'(imem_req_o), 32'h0);
      else if (sb.size() > 0) begin
        chk("sb_inst", inst_o, sb[0].inst);
        chk("sb_pc", pc_o, sb[0].pc);
      end else begin
        chk("sb_bubble_inst", inst_o, 32'h0);
        chk("sb_bubble_pc", pc_o, 32'h0);
      end
      if (imem_req_o & imem_ready_i) chk("sb_addr", imem_addr_o, exp_pc);
      rsp = imem_valid_i;
      if (~stall_i & ~redirect_i & (sb.size() > 0)) begin
        void'(sb.pop_front());
        consumed++;
      end
      if (redirect_i) begin
        sb.delete();
        stale = pend & ~rsp;
        exp_pc = redirect_pc_i & 32'hFFFF_FFFC;
      end else begin
        if (rsp) begin
          if (stale) stale = 1'b0;
          else sb.push_back({imem_rdata_i, pend_addr});
        end
        if (imem_req_o & imem_ready_i) exp_pc += 32'd4;
      end
      edge_step();
    end
    chk("sb_progress", 32'(consumed > 20), 32'h1);
    stall_i = 1'b0;
    redirect_i = 1'b0;
    imem_ready_i = 1'b1;
    mv = 1'b0;
    for (int n = 0; n < 10 && !pend; n++) begin
      mem_out();
      #1;
      edge_step();
    end
    chk("mid_pending", 32'(pend), 32'h1);
    mem_out();
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(imem_req_o), 32'h0);
    chk("mid_rst_inst", inst_o, 32'h0);
    chk("mid_rst_pc", pc_o, 32'h0);
    chk("mid_rst_addr", imem_addr_o, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pend = 1'b0;
    imem_valid_i = 1'b1;
    imem_rdata_i = 32'h0000_0BAD;
    #1;
    chk("post_req", 32'(imem_req_o), 32'h1);
    chk("post_addr", imem_addr_o, 32'h0);
    edge_step();
    mv = 1'b1;
    mem_out();
    #1;
    chk("late_ignored_inst", inst_o, 32'h0);
    chk("late_ignored_pc", pc_o, 32'h0);
    edge_step();
    mv = 1'b0;
    mem_out();
    #1;
    chk("post_first_inst", inst_o, 32'hDEAD_0000);
    chk("post_first_pc", pc_o, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
